conv_enc: RTL and testbench

- Rate-1/2, constraint-length-4 (8-state) convolutional encoder: the transmit-side counterpart of the Viterbi decoder's ACS/traceback path.
- Accepts a framed serial bit stream over a valid/ready handshake and emits one 2-bit code symbol per input bit.
- Appends 3 zero tail bits per frame so the trellis terminates in state 0, which is where decoder traceback starts.
- Sits between the data source and the channel/modulator model in the codec testbench chain.

---
 rtl/conv_enc_if.sv | 20 ++
 rtl/conv_enc.sv | 101 ++++++++++
 tb/tb_conv_enc.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_enc_if.sv
// Serial data in / code symbols out handshake bundle for the convolutional encoder.
interface conv_enc_if;
  logic       din;
  logic       din_valid;
  logic       din_last;
  logic       din_ready;
  logic [1:0] code;
  logic       code_valid;
  logic       code_ready;

  modport master (
    output din, din_valid, din_last, code_ready,
    input  din_ready, code, code_valid
  );

  modport slave (
    input  din, din_valid, din_last, code_ready,
    output din_ready, code, code_valid
  );
endinterface

// File: rtl/conv_enc.sv
// Rate-1/2, K=4 convolutional encoder with per-frame zero-tail termination.
module conv_enc #(
  parameter logic [3:0]  G0      = 4'b1111,
  parameter logic [3:0]  G1      = 4'b1101,
  parameter int unsigned MAX_LEN = 256,
  localparam int unsigned CNT_W  = $clog2(MAX_LEN) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  conv_enc_if.slave        bus,
  output logic             frame_done,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {IDLE, DATA, TAIL, DONE} fsm_t;

  fsm_t             fsm;
  logic [2:0]       state;
  logic [1:0]       tail_cnt;
  logic             adv;
  logic             accept;
  logic             load;
  logic             b;
  logic [3:0]       reg4;
  logic [CNT_W-1:0] cnt_inc;

  // The output register may take a new symbol when empty or being drained.
  assign adv           = (!bus.code_valid || bus.code_ready) && enable;
  assign bus.din_ready = adv && (fsm == IDLE || fsm == DATA);
  assign accept        = bus.din_valid && bus.din_ready;
  assign load          = accept || (fsm == TAIL && adv);
  assign b             = (fsm == TAIL) ? 1'b0 : bus.din;
  assign reg4          = {b, state};
  assign cnt_inc       = bit_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm            <= IDLE;
      state          <= 3'b000;
      tail_cnt       <= 2'd0;
      bit_cnt        <= '0;
      frame_done     <= 1'b0;
      bus.code       <= 2'b00;
      bus.code_valid <= 1'b0;
    end else if (!enable) begin
      fsm            <= IDLE;
      state          <= 3'b000;
      tail_cnt       <= 2'd0;
      bit_cnt        <= '0;
      frame_done     <= 1'b0;
      bus.code       <= 2'b00;
      bus.code_valid <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (load) begin
        bus.code       <= {^(reg4 & G1), ^(reg4 & G0)};
        bus.code_valid <= 1'b1;
        state          <= {b, state[2:1]};
      end else if (bus.code_valid && bus.code_ready) begin
        bus.code_valid <= 1'b0;
      end

      unique case (fsm)
        IDLE: begin
          if (accept) begin
            bit_cnt  <= cnt_inc;
            tail_cnt <= 2'd0;
            fsm      <= bus.din_last ? TAIL : DATA;
          end
        end
        DATA: begin
          if (accept) begin
            bit_cnt <= cnt_inc;
            // Hitting MAX_LEN terminates the frame regardless of din_last.
            if (bus.din_last || cnt_inc == CNT_W'(MAX_LEN)) begin
              tail_cnt <= 2'd0;
              fsm      <= TAIL;
            end
          end
        end
        TAIL: begin
          if (adv) begin
            tail_cnt <= tail_cnt + 2'd1;
            if (tail_cnt == 2'd2) fsm <= DONE;
          end
        end
        DONE: begin
          if (bus.code_valid && bus.code_ready) begin
            frame_done <= 1'b1;
            bit_cnt    <= '0;
            fsm        <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_enc.sv
// Directed bench for conv_enc: golden, back-to-back, backpressure, forced termination, abort.
module tb_conv_enc;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       fd0;
  logic       fd1;
  logic [8:0] bc0;
  logic [2:0] bc1;

  always #5 clk = ~clk;

  conv_enc_if bus0();
  conv_enc_if bus1();

  conv_enc u_dut (
    .clk(clk), .rst(rst), .enable(enable), .bus(bus0.slave),
    .frame_done(fd0), .bit_cnt(bc0)
  );

  conv_enc #(.MAX_LEN(4)) u_dut4 (
    .clk(clk), .rst(rst), .enable(enable), .bus(bus1.slave),
    .frame_done(fd1), .bit_cnt(bc1)
  );

  typedef struct {
    string       name;
    int          nbits;
    logic [7:0]  bits;   // bit i is the i-th data bit sent
    int          nsym;
    logic [15:0] syms;   // symbol i expected at syms[2*i +: 2]
  } frame_t;

  int         checks = 0;
  int         errors = 0;
  int         nfd0 = 0;
  int         nfd1 = 0;
  logic [1:0] rx0[$];
  logic [1:0] rx1[$];
  logic       stall0 = 1'b0;
  logic [1:0] stall_code0 = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Downstream monitor: collects accepted symbols and checks stall behaviour.
  always @(negedge clk) begin
    if (rst) begin
      if (bus0.code_valid && bus0.code_ready) rx0.push_back(bus0.code);
      if (bus1.code_valid && bus1.code_ready) rx1.push_back(bus1.code);
      if (fd0) nfd0++;
      if (fd1) nfd1++;
      if (stall0 && enable) begin
        check("stall_valid_hold", 32'(bus0.code_valid), 32'd1);
        check("stall_code_hold", 32'(bus0.code), 32'(stall_code0));
      end
      if (bus0.code_valid && !bus0.code_ready)
        check("stall_din_ready", 32'(bus0.din_ready), 32'd0);
      stall0      = bus0.code_valid && !bus0.code_ready;
      stall_code0 = bus0.code;
    end
  end

  task automatic send_bit(input logic d, input logic l);
    int t = 0;
    bus0.din       = d;
    bus0.din_valid = 1'b1;
    bus0.din_last  = l;
    forever begin
      @(negedge clk);
      if (bus0.din_ready) break;
      t++;
      if (t > 100) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    bus0.din_valid = 1'b0;
    bus0.din_last  = 1'b0;
  endtask

  task automatic send_frame(input frame_t f);
    for (int i = 0; i < f.nbits; i++) send_bit(f.bits[i], i == f.nbits - 1);
  endtask

  task automatic wait_fd(input int target);
    for (int c = 0; c < 300 && nfd0 < target; c++) @(negedge clk);
    @(posedge clk); #1;
    check("frame_done_count", 32'(nfd0), 32'(target));
  endtask

  task automatic compare_rx(input string name, input logic [1:0] q[$], input logic [15:0] syms,
                            input int nsym, input int off);
    for (int i = 0; i < nsym; i++) begin
      logic [1:0]  e;
      logic [31:0] act;
      e   = syms[2*i +: 2];
      act = (off + i < q.size()) ? 32'(q[off + i]) : 32'hdead;
      check(name, act, 32'(e));
    end
  endtask

  frame_t tbl[3];
  frame_t forced;
  int     base;
  int     off;
  int     acc;
  int     nsym;

  initial begin
    tbl[0] = '{"golden", 4, 8'b0000_1101, 7,
               {2'b00, 2'b11, 2'b10, 2'b10, 2'b11, 2'b10, 2'b11, 2'b11}};
    tbl[1] = '{"one_bit", 1, 8'b0000_0001, 4,
               {8'h00, 2'b11, 2'b01, 2'b11, 2'b11}};
    tbl[2] = '{"zero_bit", 1, 8'b0000_0000, 4, 16'h0000};
    forced = '{"forced", 4, 8'b0000_1111, 7,
               {2'b00, 2'b11, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b11}};

    bus0.din = 1'b0; bus0.din_valid = 1'b0; bus0.din_last = 1'b0; bus0.code_ready = 1'b1;
    bus1.din = 1'b0; bus1.din_valid = 1'b0; bus1.din_last = 1'b0; bus1.code_ready = 1'b1;

    // Reset and idle
    enable = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_code_valid", 32'(bus0.code_valid), 32'd0);
    check("rst_state", 32'(u_dut.state), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("idle_code_valid", 32'(bus0.code_valid), 32'd0);
    check("idle_din_ready", 32'(bus0.din_ready), 32'd1);
    check("idle_bit_cnt", 32'(bc0), 32'd0);
    check("idle_code", 32'(bus0.code), 32'd0);
    check("idle_frame_done", 32'(fd0), 32'd0);
    @(posedge clk); #1;

    // Table frames sent back to back with code_ready held high
    rx0.delete();
    base = nfd0;
    for (int i = 0; i < 3; i++) send_frame(tbl[i]);
    wait_fd(base + 3);
    check("b2b_symbol_count", 32'(rx0.size()), 32'd15);
    off = 0;
    for (int i = 0; i < 3; i++) begin
      compare_rx(tbl[i].name, rx0, tbl[i].syms, tbl[i].nsym, off);
      off += tbl[i].nsym;
    end
    check("b2b_final_state", 32'(u_dut.state), 32'd0);
    check("b2b_bit_cnt_clear", 32'(bc0), 32'd0);

    // Backpressure: alternating ready plus a 5-cycle hold while the tail is pending
    rx0.delete();
    base = nfd0;
    fork
      send_frame(tbl[0]);
      begin
        for (int k = 0; k < 200 && nfd0 == base; k++) begin
          bus0.code_ready = (k >= 9 && k < 14) ? 1'b0 : (k % 2 == 0);
          @(posedge clk); #1;
        end
        bus0.code_ready = 1'b1;
      end
    join
    wait_fd(base + 1);
    check("bp_symbol_count", 32'(rx0.size()), 32'd7);
    compare_rx("bp_golden", rx0, tbl[0].syms, 7, 0);
    check("bp_final_state", 32'(u_dut.state), 32'd0);

    // Forced termination at MAX_LEN=4 with din_last never asserted
    rx1.delete();
    bus1.din = 1'b1;
    bus1.din_valid = 1'b1;
    acc = 0;
    nsym = 0;
    for (int c = 0; c < 60 && nsym < 7; c++) begin
      @(negedge clk);
      if (acc == 4) check("ft_din_ready_low", 32'(bus1.din_ready), 32'd0);
      if (bus1.din_ready) acc++;
      if (bus1.code_valid && bus1.code_ready) nsym++;
      if (nsym == 7) check("ft_bit_cnt_max", 32'(bc1), 32'd4);
      @(posedge clk); #1;
    end
    bus1.din_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    check("ft_accepted_bits", 32'(acc), 32'd4);
    check("ft_frame_done", 32'(nfd1), 32'd1);
    check("ft_bit_cnt_clear", 32'(bc1), 32'd0);
    check("ft_symbol_count", 32'(rx1.size()), 32'd7);
    compare_rx("ft_symbols", rx1, forced.syms, 7, 0);

    // Abort after two data bits, then restart the full frame
    rx0.delete();
    base = nfd0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    enable = 1'b0;
    @(negedge clk);
    check("abort_din_ready", 32'(bus0.din_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_code_valid", 32'(bus0.code_valid), 32'd0);
    check("abort_bit_cnt", 32'(bc0), 32'd0);
    check("abort_state", 32'(u_dut.state), 32'd0);
    rx0.delete();
    repeat (5) @(negedge clk);
    check("abort_no_tail", 32'(rx0.size()), 32'd0);
    check("abort_no_frame_done", 32'(nfd0), 32'(base));
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    send_frame(tbl[0]);
    wait_fd(base + 1);
    check("restart_symbol_count", 32'(rx0.size()), 32'd7);
    compare_rx("restart_golden", rx0, tbl[0].syms, 7, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
